// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment scan driver.
// Segment patterns are active-high, bit order gfedcba (seg[0]=a .. seg[6]=g).
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Scan slot phase: DEAD is the anti-ghosting gap at the start of a slot.
    typedef enum logic {
        DEAD = 1'b0,
        ON   = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: 4-bit code to active-high 7-segment pattern.
// Non-BCD codes (10-15) render as a dash so corrupt digits stay visible.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    // Straight lookup; polarity is handled by the caller's output register.
    always_comb begin
        pattern = SEG_DASH;
        case (code)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: latches BCD digits and time-multiplexes them onto a
// common-segment 7-segment display, one digit per scan slot, with dead time
// at the start of each slot and frame-synchronous display updates.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int DEAD_CYCLES    = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    localparam int IDX_W         = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic                  load,
    input  logic                  blank,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick,
    output logic [IDX_W-1:0]      digit_idx
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam logic [6:0]        SEG_INACT = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic [DIGITS-1:0] AN_INACT  = {DIGITS{AN_ACTIVE_LOW}};

    logic [PRE_W-1:0]    prescaler_q, prescaler_d;
    logic [IDX_W-1:0]    digit_idx_q, digit_idx_d;
    scan_state_e         state_q, state_d;
    logic [4*DIGITS-1:0] pending_q, pending_d;
    logic [4*DIGITS-1:0] active_q, active_d;
    logic                pend_valid_q, pend_valid_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_tick_q, frame_tick_d;

    logic                pre_wrap;
    logic                frame_boundary;
    logic [3:0]          sel_code;
    logic [6:0]          sel_pattern;
    logic [DIGITS-1:0]   an_onehot;
    logic [DIGITS-1:0]   lead_zero;

    // Slot prescaler, digit index and the dead/on phase of the coming slot cycle.
    always_comb begin
        pre_wrap       = (prescaler_q == PRE_W'(SCAN_DIV - 1));
        frame_boundary = pre_wrap && (digit_idx_q == IDX_W'(DIGITS - 1));
        prescaler_d    = pre_wrap ? '0 : prescaler_q + PRE_W'(1);
        digit_idx_d    = digit_idx_q;
        if (pre_wrap) begin
            digit_idx_d = (digit_idx_q == IDX_W'(DIGITS - 1)) ? '0 : digit_idx_q + IDX_W'(1);
        end
        state_d = (int'(prescaler_d) < DEAD_CYCLES) ? DEAD : ON;
    end

    // Load handshake: pending collects loads, active only changes at frame boundaries.
    always_comb begin
        pending_d    = pending_q;
        pend_valid_d = pend_valid_q;
        active_d     = active_q;
        if (frame_boundary && load) begin
            active_d     = digits_in;
            pending_d    = digits_in;
            pend_valid_d = 1'b0;
        end else begin
            if (frame_boundary && pend_valid_q) begin
                active_d     = pending_q;
                pend_valid_d = 1'b0;
            end
            if (load) begin
                pending_d    = digits_in;
                pend_valid_d = 1'b1;
            end
        end
    end

`ifdef SEG7_LZB_EN
    // Mark digits that are zero with every more significant digit also zero; digit 0 never blanks.
    always_comb begin
        logic higher_zero;
        lead_zero   = '0;
        higher_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            higher_zero  = higher_zero && (active_q[4*i +: 4] == 4'd0);
            lead_zero[i] = higher_zero;
        end
    end
`else
    assign lead_zero = '0;
`endif

    assign sel_code = active_q[4*digit_idx_q +: 4];

    seg7_decode u_decode (
        .code    (sel_code),
        .pattern (sel_pattern)
    );

    // Next registered display outputs, polarity applied here so the decoder stays active-high.
    always_comb begin
        an_onehot    = DIGITS'(1) << digit_idx_q;
        an_d         = AN_INACT;
        seg_d        = SEG_INACT;
        frame_tick_d = frame_boundary;
        if ((state_q == ON) && !blank) begin
            an_d  = AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
            seg_d = lead_zero[digit_idx_q] ? SEG_OFF : sel_pattern;
            if (SEG_ACTIVE_LOW) begin
                seg_d = ~seg_d;
            end
        end
    end

    // All state registers; reset leaves the display dark and scanning from digit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler_q  <= '0;
            digit_idx_q  <= '0;
            state_q      <= DEAD;
            pending_q    <= '0;
            active_q     <= '0;
            pend_valid_q <= 1'b0;
            seg_q        <= SEG_INACT;
            an_q         <= AN_INACT;
            frame_tick_q <= 1'b0;
        end else begin
            prescaler_q  <= prescaler_d;
            digit_idx_q  <= digit_idx_d;
            state_q      <= state_d;
            pending_q    <= pending_d;
            active_q     <= active_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;
    assign digit_idx  = digit_idx_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed bench for seg7_scan_driver with DIGITS=4,
// SCAN_DIV=8, DEAD_CYCLES=2 and active-low segments and anodes.
// Edge numbers count rising clock edges since the last reset release.
module tb_seg7_scan_driver;

    logic        clk;
    logic        reset;
    logic [15:0] digits_in;
    logic        load;
    logic        blank;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;
    logic [1:0]  digit_idx;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

`ifdef SEG7_LZB_EN
    localparam logic [6:0] LZ_SEG = 7'h7F;
`else
    localparam logic [6:0] LZ_SEG = 7'h40;
`endif

    seg7_scan_driver #(
        .DIGITS         (4),
        .SCAN_DIV       (8),
        .DEAD_CYCLES    (2),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits_in  (digits_in),
        .load       (load),
        .blank      (blank),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick),
        .digit_idx  (digit_idx)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            edge_n++;
        end
        @(negedge clk);
    endtask

    task automatic advanceTo(input int target);
        while (edge_n < target) cycles(1);
    endtask

    task automatic applyStimulus(input logic ld, input logic [15:0] d, input logic blk);
        load      = ld;
        digits_in = d;
        blank     = blk;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
        checks++;
        assert (an === exp_an) else begin
            failures++;
            $error("[TB] FAIL %s an observed=%b expected=%b (edge %0d)", tag, an, exp_an, edge_n);
        end
        checks++;
        assert (seg === exp_seg) else begin
            failures++;
            $error("[TB] FAIL %s seg observed=%h expected=%h (edge %0d)", tag, seg, exp_seg, edge_n);
        end
    endtask

    task automatic checkScan(input string tag, input logic [1:0] exp_idx, input logic exp_tick);
        checks++;
        assert (digit_idx === exp_idx) else begin
            failures++;
            $error("[TB] FAIL %s digit_idx observed=%0d expected=%0d (edge %0d)", tag, digit_idx, exp_idx, edge_n);
        end
        checks++;
        assert (frame_tick === exp_tick) else begin
            failures++;
            $error("[TB] FAIL %s frame_tick observed=%b expected=%b (edge %0d)", tag, frame_tick, exp_tick, edge_n);
        end
    endtask

    task automatic checkPend(input string tag, input logic exp_pv);
        checks++;
        assert (dut.pend_valid_q === exp_pv) else begin
            failures++;
            $error("[TB] FAIL %s pend_valid observed=%b expected=%b (edge %0d)", tag, dut.pend_valid_q, exp_pv, edge_n);
        end
    endtask

    // Directed sequence; frame boundaries fall on edges 32, 64, 96, ...
    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        edge_n = 0;

        checkOutput("reset_out", 4'b1111, 7'h7F);
        checkScan("reset_scan", 2'd0, 1'b0);

        // Dead time then digit 0 showing "0".
        advanceTo(1);  checkOutput("dead_e1", 4'b1111, 7'h7F);
        advanceTo(2);  checkOutput("dead_e2", 4'b1111, 7'h7F);
        advanceTo(3);  checkOutput("on_e3", 4'b1110, 7'h40);
        advanceTo(8);  checkScan("idx_step", 2'd1, 1'b0);
        advanceTo(31); checkScan("pre_tick", 2'd3, 1'b0);
        advanceTo(32); checkScan("first_tick", 2'd0, 1'b1);
        advanceTo(33); checkScan("tick_one_cycle", 2'd0, 1'b0);

        // Mid-frame load of 1234 waits for the next frame.
        applyStimulus(1'b1, 16'h1234, 1'b0);
        cycles(1);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        checkPend("pend_set", 1'b1);
        advanceTo(36); checkOutput("hold_d0", 4'b1110, 7'h40);
        advanceTo(44); checkOutput("hold_d1", 4'b1101, 7'h40);
        advanceTo(64); checkScan("tick_frame2", 2'd0, 1'b1);
        checkPend("pend_clear", 1'b0);
        advanceTo(65); checkOutput("slot_dead", 4'b1111, 7'h7F);
        advanceTo(68); checkOutput("1234_d0", 4'b1110, 7'h19);
        advanceTo(76); checkOutput("1234_d1", 4'b1101, 7'h30);
        advanceTo(84); checkOutput("1234_d2", 4'b1011, 7'h24);
        advanceTo(92); checkOutput("1234_d3", 4'b0111, 7'h79);

        // Load on the frame-boundary cycle goes straight to the display.
        advanceTo(95);
        applyStimulus(1'b1, 16'h0009, 1'b0);
        cycles(1);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        checkPend("boundary_pend", 1'b0);
        advanceTo(100); checkOutput("0009_d0", 4'b1110, 7'h10);
        advanceTo(108); checkOutput("0009_d1", 4'b1101, 7'h40);

        // Dash codes and the non-tearing guarantee.
        applyStimulus(1'b1, 16'hA0F5, 1'b0);
        cycles(1);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        advanceTo(116); checkOutput("notear_d2", 4'b1011, 7'h40);
        advanceTo(132); checkOutput("a0f5_d0", 4'b1110, 7'h12);
        advanceTo(140); checkOutput("a0f5_d1", 4'b1101, 7'h3F);
        advanceTo(148); checkOutput("a0f5_d2", 4'b1011, 7'h40);
        advanceTo(156); checkOutput("a0f5_d3", 4'b0111, 7'h3F);

        // Blank for a whole frame; scanning cadence continues.
        advanceTo(159);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 32; i++) begin
            cycles(1);
            checkOutput("blank_frame", 4'b1111, 7'h7F);
            if (edge_n == 168) checkScan("blank_idx", 2'd1, 1'b0);
        end
        checkScan("blank_pre_tick", 2'd3, 1'b0);
        cycles(1);
        checkScan("blank_tick", 2'd0, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        advanceTo(196); checkOutput("unblank_d0", 4'b1110, 7'h12);

        // Asynchronous reset in the middle of a lit slot.
        cycles(1);
        reset = 1'b1;
        #1;
        checkOutput("reset_mid_out", 4'b1111, 7'h7F);
        checkScan("reset_mid_scan", 2'd0, 1'b0);
        @(negedge clk);
        reset  = 1'b0;
        edge_n = 0;
        advanceTo(2); checkOutput("restart_dead", 4'b1111, 7'h7F);
        advanceTo(3); checkOutput("restart_on", 4'b1110, 7'h40);
        advanceTo(8); checkScan("restart_idx", 2'd1, 1'b0);

        // Leading zeros: blanked with SEG7_LZB_EN, literal "0" otherwise.
        advanceTo(9);
        applyStimulus(1'b1, 16'h0050, 1'b0);
        cycles(1);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        advanceTo(36); checkOutput("0050_d0", 4'b1110, 7'h40);
        advanceTo(44); checkOutput("0050_d1", 4'b1101, 7'h12);
        advanceTo(52); checkOutput("0050_d2", 4'b1011, LZ_SEG);
        advanceTo(60); checkOutput("0050_d3", 4'b0111, LZ_SEG);
        advanceTo(61);
        applyStimulus(1'b1, 16'h0000, 1'b0);
        cycles(1);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        advanceTo(68); checkOutput("0000_d0", 4'b1110, 7'h40);
        advanceTo(76); checkOutput("0000_d1", 4'b1101, LZ_SEG);
        advanceTo(84); checkOutput("0000_d2", 4'b1011, LZ_SEG);
        advanceTo(92); checkOutput("0000_d3", 4'b0111, LZ_SEG);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
